memory_ctrl: RTL and testbench
==============================

// Module: memory_ctrl
// PURPOSE
//  Single-port RAM slave directly downstream of the imem/dmem arbiter; consumes its
//  memory_valid/instr/addr/wdata/wstrb request and returns memory_ready/memory_rdata.
//  Models on-chip memory with programmable wait states, byte-lane writes and an
//  out-of-range error response so that the core never hangs on a bad address.
// PARAMETERS
//  BASE_ADDR   32'h0  byte address of word 0 of the RAM window
//  DEPTH_LOG2  12     log2 of RAM depth in 32-bit words (default 4096 words = 16 KiB)
//  RD_WAIT     0      extra wait cycles for reads (wstrb==0), 0..15
//  WR_WAIT     0      extra wait cycles for writes (wstrb!=0), 0..15
// PORTS
//  clock         in   1   rising-edge clock
//  reset         in   1   synchronous, active-low reset
//  memory_valid  in   1   request valid; held by arbiter until memory_ready
//  memory_instr  in   1   1 = instruction fetch (informational; same timing)
//  memory_addr   in   32  byte address; bits [1:0] ignored (word access)
//  memory_wdata  in   32  write data, lane i = bits [8i+7:8i]
//  memory_wstrb  in   4   byte write enables; 4'b0000 = read
//  memory_rdata  out  32  read data, valid only while memory_ready=1
//  memory_ready  out  1   one-cycle completion pulse
//  memory_error  out  1   one-cycle pulse with memory_ready for out-of-range access
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE, wait counter=0, memory_ready=0,
//    memory_rdata=0, memory_error=0, latched request cleared. RAM contents NOT reset.
//    Reset mid-transaction drops the in-flight request; no ready pulse is produced.
//  - FSM: IDLE, WAIT, RESP.
//    IDLE: if memory_valid=1 -> latch addr/wdata/wstrb/instr; load counter with
//          RD_WAIT or WR_WAIT; go WAIT if counter>0 else RESP.
//    WAIT: memory_valid ignored (arbiter holds it); decrement counter; at 1 -> RESP.
//    RESP: memory_ready=1 this cycle. If memory_valid=1 in this same cycle it is a
//          NEW request (arbiter reissues combinationally on ready): latch it and
//          go WAIT/RESP as from IDLE (back-to-back); else go IDLE.
//  - Latency: ready asserted exactly (WAIT+1) cycles after the accepting edge;
//    WAIT=0 gives ready on the cycle after acceptance; sustained throughput 1/(WAIT+1).
//  - In range: word index = (addr - BASE_ADDR)>>2 < 2**DEPTH_LOG2 (unsigned 32-bit
//    subtract; addr < BASE_ADDR wraps and is out of range).
//  - Read: memory_rdata = RAM[index], registered, presented in RESP cycle.
//  - Write: committed on the edge entering RESP, only lanes with wstrb[i]=1 change;
//    memory_rdata=0 during a write response.
//  - Out of range: no RAM update, memory_rdata=0, memory_error=1 with memory_ready.
//  - memory_rdata/memory_error are 0 whenever memory_ready=0.
//  - Wait counter 4 bits; RD_WAIT/WR_WAIT >15 is illegal (elaboration assert).
// TESTING
//  1 RD_WAIT=0: write 0xDEADBEEF @0x10 wstrb=F, then read @0x10 -> ready 1 cycle
//    after each acceptance, rdata=0xDEADBEEF, error=0.
//  2 Byte lanes: over 0xDEADBEEF write 0x00001100 wstrb=4'b0010 -> read 0xDEAD11EF.
//  3 RD_WAIT=3: read held valid -> ready exactly 4 cycles after acceptance, single pulse.
//  4 Back-to-back: new valid in RESP cycle -> accepted same edge, next ready after
//    WAIT+1 cycles, no idle bubble.
//  5 Out of range: read @BASE_ADDR+(4<<DEPTH_LOG2) and write @BASE_ADDR-4 -> ready+error,
//    rdata=0, RAM unchanged.
//  6 Reset mid-WAIT (RD_WAIT=5, reset low at cycle 2) -> no ready; prior RAM data intact.

Source files
------------

// File: rtl/memory_ctrl.sv
// Single-port on-chip RAM slave behind the imem/dmem arbiter: programmable wait
// states, byte-lane writes and an error response for addresses outside the window.
module memory_ctrl #(
   parameter logic [31:0] BASE_ADDR  = 32'h0,
   parameter int unsigned DEPTH_LOG2 = 12,
   parameter int unsigned RD_WAIT    = 0,
   parameter int unsigned WR_WAIT    = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        memory_valid,
   input  logic        memory_instr,
   input  logic [31:0] memory_addr,
   input  logic [31:0] memory_wdata,
   input  logic [3:0]  memory_wstrb,
   output logic [31:0] memory_rdata,
   output logic        memory_ready,
   output logic        memory_error
);

   if (RD_WAIT > 15 || WR_WAIT > 15) begin : g_bad_wait
      $error("memory_ctrl: RD_WAIT and WR_WAIT must be in 0..15");
   end

   localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
   localparam logic [3:0]  RD_LOAD = 4'(RD_WAIT);
   localparam logic [3:0]  WR_LOAD = 4'(WR_WAIT);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [31:0]     addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [3:0]      wstrb_q, wstrb_d;
   logic            instr_q, instr_d;
   logic            rd_sel_q, rd_sel_d;
   logic            error_q, error_d;

   logic            enter_resp;
   logic [3:0]      load_now;
   logic            from_wait;
   logic [31:0]     req_addr, req_wdata, offset;
   logic [3:0]      req_wstrb;
   logic            in_range, req_is_wr, ram_we, ram_re;
   logic [DEPTH_LOG2-1:0] idx;
   logic [31:0]     ram_rdata;
   logic            unused_bits;

   assign load_now = (memory_wstrb == 4'd0) ? RD_LOAD : WR_LOAD;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      instr_d    = instr_q;
      enter_resp = 1'b0;
      case (state_q)
         // RESP accepts a reissued request exactly like IDLE, giving back-to-back service
         S_IDLE, S_RESP: begin
            if (memory_valid) begin
               addr_d  = memory_addr;
               wdata_d = memory_wdata;
               wstrb_d = memory_wstrb;
               instr_d = memory_instr;
               cnt_d   = load_now;
               if (load_now != 4'd0) begin
                  state_d = S_WAIT;
               end else begin
                  state_d    = S_RESP;
                  enter_resp = 1'b1;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd1) begin
               state_d    = S_RESP;
               enter_resp = 1'b1;
               cnt_d      = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // The RAM access happens on the edge entering RESP; with zero wait states that is
   // the accepting edge itself, so the live request is used instead of the latched one.
   assign from_wait = (state_q == S_WAIT);
   assign req_addr  = from_wait ? addr_q  : memory_addr;
   assign req_wdata = from_wait ? wdata_q : memory_wdata;
   assign req_wstrb = from_wait ? wstrb_q : memory_wstrb;

   assign offset    = req_addr - BASE_ADDR;
   assign in_range  = (offset >> (DEPTH_LOG2 + 2)) == 32'd0;
   assign idx       = offset[DEPTH_LOG2+1:2];
   assign req_is_wr = (req_wstrb != 4'd0);
   assign ram_we    = enter_resp & in_range & req_is_wr & reset;
   assign ram_re    = enter_resp & in_range & ~req_is_wr;
   assign rd_sel_d  = ram_re;
   assign error_d   = enter_resp & ~in_range;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         wstrb_q  <= 4'd0;
         instr_q  <= 1'b0;
         rd_sel_q <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
         instr_q  <= instr_d;
         rd_sel_q <= rd_sel_d;
         error_q  <= error_d;
      end
   end

   // One byte-wide RAM per lane keeps byte-enable writes a plain inferred memory.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem_q [DEPTH];
      logic [7:0] rd_q;
      always_ff @(posedge clock) begin
         if (ram_we && req_wstrb[gi]) begin
            mem_q[idx] <= req_wdata[8*gi +: 8];
         end
         if (ram_re) begin
            rd_q <= mem_q[idx];
         end
      end
      assign ram_rdata[8*gi +: 8] = rd_q;
   end

   assign memory_ready = (state_q == S_RESP);
   assign memory_rdata = rd_sel_q ? ram_rdata : 32'd0;
   assign memory_error = error_q;

   assign unused_bits = ^{instr_q, offset[1:0]};

endmodule

// File: tb/tb_memory_ctrl.sv
// Directed bench for memory_ctrl: three instances with different window and
// wait-state settings, a vector table plus back-to-back and mid-wait reset sequences.
module tb_memory_ctrl;

   localparam int TIMEOUT = 40;

   logic        clock;
   logic        rst_n [3];
   logic        valid [3];
   logic        instr [3];
   logic [31:0] addr  [3];
   logic [31:0] wdata [3];
   logic [3:0]  wstrb [3];
   logic [31:0] rdata [3];
   logic        ready [3];
   logic        err   [3];

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int          k;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      int          lat;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs [$];

   // A: base 0, 4096 words, no waits. B: base 0x1000, 64 words, rd 3 / wr 1. C: 16 words, rd 5.
   memory_ctrl #(.BASE_ADDR(32'h0), .DEPTH_LOG2(12), .RD_WAIT(0), .WR_WAIT(0)) u_dut_a (
      .clock(clock), .reset(rst_n[0]), .memory_valid(valid[0]), .memory_instr(instr[0]),
      .memory_addr(addr[0]), .memory_wdata(wdata[0]), .memory_wstrb(wstrb[0]),
      .memory_rdata(rdata[0]), .memory_ready(ready[0]), .memory_error(err[0]));

   memory_ctrl #(.BASE_ADDR(32'h1000), .DEPTH_LOG2(6), .RD_WAIT(3), .WR_WAIT(1)) u_dut_b (
      .clock(clock), .reset(rst_n[1]), .memory_valid(valid[1]), .memory_instr(instr[1]),
      .memory_addr(addr[1]), .memory_wdata(wdata[1]), .memory_wstrb(wstrb[1]),
      .memory_rdata(rdata[1]), .memory_ready(ready[1]), .memory_error(err[1]));

   memory_ctrl #(.BASE_ADDR(32'h0), .DEPTH_LOG2(4), .RD_WAIT(5), .WR_WAIT(0)) u_dut_c (
      .clock(clock), .reset(rst_n[2]), .memory_valid(valid[2]), .memory_instr(instr[2]),
      .memory_addr(addr[2]), .memory_wdata(wdata[2]), .memory_wstrb(wstrb[2]),
      .memory_rdata(rdata[2]), .memory_ready(ready[2]), .memory_error(err[2]));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input int k, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, input int lat,
                               input logic [31:0] r, input logic e);
      vec_t v;
      v.k = k; v.a = a; v.d = d; v.s = s; v.lat = lat; v.exp_rdata = r; v.exp_err = e;
      return v;
   endfunction

   // Called right after a negedge; the request is accepted at the following posedge.
   task automatic issue(input int k, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
      valid[k] = 1'b1;
      instr[k] = (s == 4'd0);
      addr[k]  = a;
      wdata[k] = d;
      wstrb[k] = s;
   endtask

   task automatic drop(input int k);
      valid[k] = 1'b0;
      wstrb[k] = 4'd0;
   endtask

   task automatic wait_ready(input int k, output int lat);
      lat = 0;
      do begin
         @(negedge clock);
         lat++;
      end while (ready[k] !== 1'b1 && lat < TIMEOUT);
   endtask

   task automatic apply_vec(input vec_t v, input string tag);
      int lat;
      issue(v.k, v.a, v.d, v.s);
      wait_ready(v.k, lat);
      $display("[TB] %s dut%0d addr=%h wstrb=%h lat=%0d rdata=%h err=%0b",
               tag, v.k, v.a, v.s, lat, rdata[v.k], err[v.k]);
      chk({tag, "_lat"},   32'(lat),   32'(v.lat));
      chk({tag, "_rdata"}, rdata[v.k], v.exp_rdata);
      chk({tag, "_err"},   {31'd0, err[v.k]}, {31'd0, v.exp_err});
      drop(v.k);
      @(negedge clock);
      chk({tag, "_pulse"}, {31'd0, ready[v.k]}, 32'd0);
   endtask

   // Second request presented in the RESP cycle of the first, with valid never dropped.
   task automatic back_to_back(input int k, input logic [31:0] a1, input logic [31:0] r1,
                               input logic [31:0] a2, input logic [31:0] r2,
                               input int exp_lat, input string tag);
      int lat;
      issue(k, a1, 32'd0, 4'd0);
      wait_ready(k, lat);
      chk({tag, "_lat1"},   32'(lat), 32'(exp_lat));
      chk({tag, "_rdata1"}, rdata[k], r1);
      addr[k] = a2;
      wait_ready(k, lat);
      $display("[TB] %s dut%0d second addr=%h lat=%0d rdata=%h", tag, k, a2, lat, rdata[k]);
      chk({tag, "_lat2"},   32'(lat), 32'(exp_lat));
      chk({tag, "_rdata2"}, rdata[k], r2);
      drop(k);
      @(negedge clock);
      chk({tag, "_idle"}, {31'd0, ready[k]}, 32'd0);
   endtask

   initial begin
      int seen;
      for (int k = 0; k < 3; k++) begin
         rst_n[k] = 1'b0;
         valid[k] = 1'b0;
         instr[k] = 1'b0;
         addr[k]  = 32'd0;
         wdata[k] = 32'd0;
         wstrb[k] = 4'd0;
      end

      // Dut A: basic write/read, byte lanes, window edges and out-of-range traffic
      vecs.push_back(mk(0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1, 32'h0,         1'b0));
      vecs.push_back(mk(0, 32'h0000_0010, 32'h0,         4'h0, 1, 32'hDEAD_BEEF, 1'b0));
      vecs.push_back(mk(0, 32'h0000_0010, 32'h0000_1100, 4'h2, 1, 32'h0,         1'b0));
      vecs.push_back(mk(0, 32'h0000_0010, 32'h0,         4'h0, 1, 32'hDEAD_11EF, 1'b0));
      vecs.push_back(mk(0, 32'h0000_0013, 32'h0,         4'h0, 1, 32'hDEAD_11EF, 1'b0));
      vecs.push_back(mk(0, 32'h0000_0014, 32'hA5A5_A5A5, 4'hF, 1, 32'h0,         1'b0));
      vecs.push_back(mk(0, 32'h0000_0014, 32'h1234_5678, 4'h9, 1, 32'h0,         1'b0));
      vecs.push_back(mk(0, 32'h0000_0014, 32'h0,         4'h0, 1, 32'h12A5_A578, 1'b0));
      vecs.push_back(mk(0, 32'h0000_3FFC, 32'hCAFE_F00D, 4'hF, 1, 32'h0,         1'b0));
      vecs.push_back(mk(0, 32'hFFFF_FFFC, 32'h1111_1111, 4'hF, 1, 32'h0,         1'b1));
      vecs.push_back(mk(0, 32'h0000_4000, 32'h0,         4'h0, 1, 32'h0,         1'b1));
      vecs.push_back(mk(0, 32'h0000_4010, 32'h0,         4'h0, 1, 32'h0,         1'b1));
      vecs.push_back(mk(0, 32'h0000_3FFC, 32'h0,         4'h0, 1, 32'hCAFE_F00D, 1'b0));
      vecs.push_back(mk(0, 32'h0000_0010, 32'h0,         4'h0, 1, 32'hDEAD_11EF, 1'b0));
      // Dut B: offset window, read latency 4, write latency 2
      vecs.push_back(mk(1, 32'h0000_1020, 32'h0BAD_F00D, 4'hF, 2, 32'h0,         1'b0));
      vecs.push_back(mk(1, 32'h0000_1020, 32'h0,         4'h0, 4, 32'h0BAD_F00D, 1'b0));
      vecs.push_back(mk(1, 32'h0000_10FC, 32'h7766_5544, 4'hF, 2, 32'h0,         1'b0));
      vecs.push_back(mk(1, 32'h0000_0FFC, 32'h9999_9999, 4'hF, 2, 32'h0,         1'b1));
      vecs.push_back(mk(1, 32'h0000_1100, 32'h0,         4'h0, 4, 32'h0,         1'b1));
      vecs.push_back(mk(1, 32'h0000_10FC, 32'h0,         4'h0, 4, 32'h7766_5544, 1'b0));
      // Dut C: preload for the reset test, read latency 6
      vecs.push_back(mk(2, 32'h0000_0008, 32'h1357_9BDF, 4'hF, 1, 32'h0,         1'b0));
      vecs.push_back(mk(2, 32'h0000_0008, 32'h0,         4'h0, 6, 32'h1357_9BDF, 1'b0));

      repeat (3) @(posedge clock);
      @(negedge clock);
      for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("reset_ready%0d", k), {31'd0, ready[k]}, 32'd0);
         chk($sformatf("reset_rdata%0d", k), rdata[k], 32'd0);
         chk($sformatf("reset_err%0d", k),   {31'd0, err[k]}, 32'd0);
      end

      for (int i = 0; i < vecs.size(); i++) begin
         apply_vec(vecs[i], $sformatf("v%0d", i));
      end

      back_to_back(0, 32'h0000_0010, 32'hDEAD_11EF, 32'h0000_0014, 32'h12A5_A578, 1, "b2b_a");
      back_to_back(1, 32'h0000_1020, 32'h0BAD_F00D, 32'h0000_10FC, 32'h7766_5544, 4, "b2b_b");

      // Reset two cycles into a 5-wait read: the request must vanish without a pulse
      issue(2, 32'h0000_0008, 32'h0, 4'h0);
      @(negedge clock);
      @(negedge clock);
      chk("rst_mid_busy", {31'd0, ready[2]}, 32'd0);
      rst_n[2] = 1'b0;
      drop(2);
      @(negedge clock);
      rst_n[2] = 1'b1;
      chk("rst_mid_ready", {31'd0, ready[2]}, 32'd0);
      chk("rst_mid_rdata", rdata[2], 32'd0);
      chk("rst_mid_err",   {31'd0, err[2]}, 32'd0);
      seen = 0;
      repeat (10) begin
         @(negedge clock);
         if (ready[2] !== 1'b0) seen++;
      end
      $display("[TB] rst_mid dut2 ready pulses after reset=%0d", seen);
      chk("rst_mid_no_ready", 32'(seen), 32'd0);
      apply_vec(mk(2, 32'h0000_0008, 32'h0, 4'h0, 6, 32'h1357_9BDF, 1'b0), "rst_after");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
